// File: rtl/call_stack_ctrl.sv
// Return-address stack for call/return prediction: circular storage with
// overwrite-oldest on overflow, tail-call replace, and checkpoint restore on flush.
module call_stack_ctrl #(
    parameter int DEPTH    = 16,
    parameter int IP_WIDTH = 48,
    parameter int PTR_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_en,
    input  logic                pushCallStack,
    input  logic                popCallStack,
    input  logic [IP_WIDTH-1:0] push_addr,
    input  logic                flush,
    input  logic [PTR_W-1:0]    flush_ptr,
    input  logic [PTR_W:0]      flush_cnt,
    output logic                pop_valid,
    output logic [IP_WIDTH-1:0] pop_addr,
    output logic [PTR_W-1:0]    cur_ptr,
    output logic [PTR_W:0]      cur_cnt,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [IP_WIDTH-1:0] mem [DEPTH];

    logic             pushE;
    logic             popE;
    logic             isEmpty;
    logic             isFull;
    logic [PTR_W-1:0] topIdx;
    logic [PTR_W-1:0] nextIdx;
    logic             memWe;
    logic [PTR_W-1:0] memWaddr;

    function automatic logic [PTR_W:0] satInc(input logic [PTR_W:0] cnt);
        return (cnt >= FULL_CNT) ? FULL_CNT : cnt + (PTR_W+1)'(1);
    endfunction

    function automatic logic [PTR_W:0] satClamp(input logic [PTR_W:0] cnt);
        return (cnt > FULL_CNT) ? FULL_CNT : cnt;
    endfunction

    always_comb begin
        pushE   = dec_en & pushCallStack & ~flush;
        popE    = dec_en & popCallStack & ~flush;
        isEmpty = (cur_cnt == '0);
        isFull  = (cur_cnt == FULL_CNT);
        topIdx  = cur_ptr - PTR_W'(1);
        nextIdx = cur_ptr + PTR_W'(1);
        // A tail call replaces the top entry in place; an empty tail call is a plain push.
        memWe    = pushE & ~rst;
        memWaddr = (popE && !isEmpty) ? topIdx : cur_ptr;
    end

    // Storage stage: contents are not reset, occupancy gates every read.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memWaddr] <= push_addr;
        end
    end

    // Control/output stage: one-cycle pop result and event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ptr   <= '0;
            cur_cnt   <= '0;
            pop_valid <= 1'b0;
            pop_addr  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (flush) begin
                cur_ptr <= flush_ptr;
                cur_cnt <= satClamp(flush_cnt);
            end else if (pushE && popE) begin
                if (!isEmpty) begin
                    pop_addr  <= mem[topIdx];
                    pop_valid <= 1'b1;
                end else begin
                    cur_ptr   <= nextIdx;
                    cur_cnt   <= satInc(cur_cnt);
                    underflow <= 1'b1;
                end
            end else if (pushE) begin
                cur_ptr  <= nextIdx;
                cur_cnt  <= satInc(cur_cnt);
                overflow <= isFull;
            end else if (popE) begin
                if (!isEmpty) begin
                    pop_addr  <= mem[topIdx];
                    pop_valid <= 1'b1;
                    cur_ptr   <= topIdx;
                    cur_cnt   <= cur_cnt - (PTR_W+1)'(1);
                end else begin
                    underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl: vector table plus an overflow/wrap sequence.
module tb_call_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_en;
    logic        pushCallStack;
    logic        popCallStack;
    logic [47:0] push_addr;
    logic        flush;
    logic [3:0]  flush_ptr;
    logic [4:0]  flush_cnt;
    logic        pop_valid;
    logic [47:0] pop_addr;
    logic [3:0]  cur_ptr;
    logic [4:0]  cur_cnt;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    call_stack_ctrl #(.DEPTH(16), .IP_WIDTH(48), .PTR_W(4)) dut (
        .clk(clk), .rst(rst), .dec_en(dec_en),
        .pushCallStack(pushCallStack), .popCallStack(popCallStack),
        .push_addr(push_addr), .flush(flush), .flush_ptr(flush_ptr),
        .flush_cnt(flush_cnt), .pop_valid(pop_valid), .pop_addr(pop_addr),
        .cur_ptr(cur_ptr), .cur_cnt(cur_cnt), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, en, pu, po;
        logic [47:0] a;
        logic        fl;
        logic [3:0]  fp;
        logic [4:0]  fc;
        logic        pv;
        logic [47:0] pa;
        logic [3:0]  ptr;
        logic [4:0]  cnt;
        logic        ov, un;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, en, pu, po, input logic [47:0] a,
                                input logic fl, input logic [3:0] fp, input logic [4:0] fc,
                                input logic pv, input logic [47:0] pa, input logic [3:0] ptr,
                                input logic [4:0] cnt, input logic ov, un);
        vec_t v;
        v.r = r; v.en = en; v.pu = pu; v.po = po; v.a = a;
        v.fl = fl; v.fp = fp; v.fc = fc;
        v.pv = pv; v.pa = pa; v.ptr = ptr; v.cnt = cnt; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, en, pu, po, input logic [47:0] a,
                         input logic fl, input logic [3:0] fp, input logic [4:0] fc);
        @(negedge clk);
        rst = r; dec_en = en; pushCallStack = pu; popCallStack = po;
        push_addr = a; flush = fl; flush_ptr = fp; flush_cnt = fc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; dec_en = 1'b0; pushCallStack = 1'b0; popCallStack = 1'b0;
        push_addr = '0; flush = 1'b0; flush_ptr = '0; flush_cnt = '0;

        //              r en pu po addr     fl fp fc   pv pa       ptr cnt ov un
        vecs[0]  = mk(1, 0, 0, 0, 48'h0,    0, 0, 0,   0, 48'h0,    0,  0, 0, 0);
        vecs[1]  = mk(0, 1, 1, 0, 48'h1000, 0, 0, 0,   0, 48'h0,    1,  1, 0, 0);
        vecs[2]  = mk(0, 1, 1, 0, 48'h2000, 0, 0, 0,   0, 48'h0,    2,  2, 0, 0);
        vecs[3]  = mk(0, 1, 1, 0, 48'h3000, 0, 0, 0,   0, 48'h0,    3,  3, 0, 0);
        vecs[4]  = mk(0, 1, 0, 1, 48'h0,    0, 0, 0,   1, 48'h3000, 2,  2, 0, 0);
        vecs[5]  = mk(0, 1, 0, 1, 48'h0,    0, 0, 0,   1, 48'h2000, 1,  1, 0, 0);
        vecs[6]  = mk(0, 1, 0, 1, 48'h0,    0, 0, 0,   1, 48'h1000, 0,  0, 0, 0);
        vecs[7]  = mk(0, 1, 0, 1, 48'h0,    0, 0, 0,   0, 48'h1000, 0,  0, 0, 1);
        vecs[8]  = mk(0, 0, 0, 0, 48'h0,    0, 0, 0,   0, 48'h1000, 0,  0, 0, 0);
        vecs[9]  = mk(0, 1, 1, 0, 48'hA0,   0, 0, 0,   0, 48'h1000, 1,  1, 0, 0);
        vecs[10] = mk(0, 1, 1, 1, 48'hB0,   0, 0, 0,   1, 48'hA0,   1,  1, 0, 0);
        vecs[11] = mk(0, 1, 0, 1, 48'h0,    0, 0, 0,   1, 48'hB0,   0,  0, 0, 0);
        vecs[12] = mk(0, 1, 1, 1, 48'hC0,   0, 0, 0,   0, 48'hB0,   1,  1, 0, 1);
        vecs[13] = mk(0, 1, 0, 1, 48'h0,    0, 0, 0,   1, 48'hC0,   0,  0, 0, 0);
        vecs[14] = mk(0, 0, 1, 0, 48'hD0,   0, 0, 0,   0, 48'hC0,   0,  0, 0, 0);
        vecs[15] = mk(0, 0, 0, 1, 48'h0,    0, 0, 0,   0, 48'hC0,   0,  0, 0, 0);
        vecs[16] = mk(0, 1, 1, 0, 48'h111,  0, 0, 0,   0, 48'hC0,   1,  1, 0, 0);
        vecs[17] = mk(0, 1, 1, 0, 48'h222,  0, 0, 0,   0, 48'hC0,   2,  2, 0, 0);
        vecs[18] = mk(0, 1, 1, 0, 48'h333,  0, 0, 0,   0, 48'hC0,   3,  3, 0, 0);
        vecs[19] = mk(0, 1, 1, 0, 48'h444,  1, 1, 1,   0, 48'hC0,   1,  1, 0, 0);
        vecs[20] = mk(0, 1, 0, 1, 48'h0,    0, 0, 0,   1, 48'h111,  0,  0, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 48'h0,    1, 2, 31,  0, 48'h111,  2, 16, 0, 0);
        vecs[22] = mk(0, 1, 0, 1, 48'h0,    0, 0, 0,   1, 48'h222,  1, 15, 0, 0);
        vecs[23] = mk(1, 1, 1, 0, 48'h999,  0, 0, 0,   0, 48'h0,    0,  0, 0, 0);
        vecs[24] = mk(0, 1, 1, 0, 48'h51,   0, 0, 0,   0, 48'h0,    1,  1, 0, 0);
        vecs[25] = mk(0, 1, 1, 0, 48'h52,   0, 0, 0,   0, 48'h0,    2,  2, 0, 0);
        vecs[26] = mk(0, 1, 1, 0, 48'h53,   0, 0, 0,   0, 48'h0,    3,  3, 0, 0);
        vecs[27] = mk(0, 1, 1, 0, 48'h54,   0, 0, 0,   0, 48'h0,    4,  4, 0, 0);
        vecs[28] = mk(0, 1, 1, 0, 48'h55,   0, 0, 0,   0, 48'h0,    5,  5, 0, 0);
        vecs[29] = mk(1, 1, 0, 1, 48'h0,    1, 7, 7,   0, 48'h0,    0,  0, 0, 0);
        vecs[30] = mk(0, 1, 0, 1, 48'h0,    0, 0, 0,   0, 48'h0,    0,  0, 0, 1);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].r, vecs[i].en, vecs[i].pu, vecs[i].po, vecs[i].a,
                  vecs[i].fl, vecs[i].fp, vecs[i].fc);
            chk($sformatf("v%0d.pop_valid", i), 64'(pop_valid), 64'(vecs[i].pv));
            chk($sformatf("v%0d.pop_addr", i),  64'(pop_addr),  64'(vecs[i].pa));
            chk($sformatf("v%0d.cur_ptr", i),   64'(cur_ptr),   64'(vecs[i].ptr));
            chk($sformatf("v%0d.cur_cnt", i),   64'(cur_cnt),   64'(vecs[i].cnt));
            chk($sformatf("v%0d.overflow", i),  64'(overflow),  64'(vecs[i].ov));
            chk($sformatf("v%0d.underflow", i), 64'(underflow), 64'(vecs[i].un));
        end

        // Overflow and wraparound: 17 pushes then 16 pops plus one empty pop.
        drive(1, 0, 0, 0, 48'h0, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            drive(0, 1, 1, 0, 48'(k), 0, 0, 0);
            chk($sformatf("ovf.push%0d.overflow", k), 64'(overflow), (k == 17) ? 64'd1 : 64'd0);
            chk($sformatf("ovf.push%0d.cur_cnt", k), 64'(cur_cnt), (k >= 16) ? 64'd16 : 64'(k));
            chk($sformatf("ovf.push%0d.cur_ptr", k), 64'(cur_ptr), 64'(k % 16));
        end
        for (int j = 1; j <= 16; j++) begin
            drive(0, 1, 0, 1, 48'h0, 0, 0, 0);
            chk($sformatf("ovf.pop%0d.pop_valid", j), 64'(pop_valid), 64'd1);
            chk($sformatf("ovf.pop%0d.pop_addr", j), 64'(pop_addr), 64'(18 - j));
            chk($sformatf("ovf.pop%0d.cur_cnt", j), 64'(cur_cnt), 64'(16 - j));
            chk($sformatf("ovf.pop%0d.cur_ptr", j), 64'(cur_ptr), 64'((17 - j) % 16));
            chk($sformatf("ovf.pop%0d.overflow", j), 64'(overflow), 64'd0);
        end
        drive(0, 1, 0, 1, 48'h0, 0, 0, 0);
        chk("ovf.emptypop.pop_valid", 64'(pop_valid), 64'd0);
        chk("ovf.emptypop.underflow", 64'(underflow), 64'd1);
        chk("ovf.emptypop.pop_addr", 64'(pop_addr), 64'd2);
        drive(0, 0, 0, 0, 48'h0, 0, 0, 0);
        chk("ovf.idle.underflow", 64'(underflow), 64'd0);
        chk("ovf.idle.cur_cnt", 64'(cur_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/call_stack_ctrl.md
CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of return-address entries, power of two.
REQ-002 SHALL have parameter IP_WIDTH, default 48: return-address width.
REQ-003 SHALL have parameter PTR_W, default 4: log2(DEPTH).
REQ-004 SHALL have port clk  input  1  clock; one clock domain, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port dec_en  input  1  qualifies push/pop from the jump decoder this cycle.
REQ-007 SHALL have port pushCallStack  input  1  call decoded; push push_addr.
REQ-008 SHALL have port popCallStack  input  1  return decoded; pop top entry.
REQ-009 SHALL have port push_addr  input  IP_WIDTH  return address (call IP plus call length).
REQ-010 SHALL have port flush  input  1  mispredict recovery; restore the checkpoint.
REQ-011 SHALL have port flush_ptr  input  PTR_W  checkpointed top pointer.
REQ-012 SHALL have port flush_cnt  input  PTR_W+1  checkpointed occupancy.
REQ-013 SHALL have port pop_valid  output  1  pop_addr holds a predicted return target.
REQ-014 SHALL have port pop_addr  output  IP_WIDTH  predicted return address.
REQ-015 SHALL have port cur_ptr  output  PTR_W  current top pointer, used for checkpointing.
REQ-016 SHALL have port cur_cnt  output  PTR_W+1  current occupancy, 0..DEPTH.
REQ-017 SHALL have port overflow  output  1  one-cycle pulse when a push overwrites the oldest entry.
REQ-018 SHALL have port underflow  output  1  one-cycle pulse on a pop while empty.

Function
REQ-019 SHALL hold storage as a circular array mem[DEPTH]; cur_ptr indexes the next free slot; the top entry is mem[cur_ptr-1 mod DEPTH].
REQ-020 SHALL define the effective operation as push_e = dec_en & pushCallStack & ~flush and pop_e = dec_en & popCallStack & ~flush.
REQ-021 SHALL, on push_e & ~pop_e, write mem[cur_ptr] <= push_addr, set cur_ptr <= cur_ptr+1 (wrapping modulo DEPTH), and set cur_cnt <= min(cur_cnt+1, DEPTH).
REQ-022 SHALL, on push_e & ~pop_e with cur_cnt==DEPTH, overwrite the oldest entry, leave cur_cnt at DEPTH, and pulse overflow=1 on the next cycle.
REQ-023 SHALL, on pop_e & ~push_e with cur_cnt>0, register pop_addr <= top entry, set pop_valid <= 1, cur_ptr <= cur_ptr-1 (wrapping), and cur_cnt <= cur_cnt-1.
REQ-024 SHALL, on pop_e & ~push_e with cur_cnt==0, set pop_valid <= 0, leave pop_addr unchanged, leave cur_ptr and cur_cnt unchanged, and pulse underflow on the next cycle.
REQ-025 SHALL, on simultaneous push_e & pop_e (tail call) with cur_cnt>0, output the old top as in REQ-023, write push_addr into the top slot, and leave cur_ptr and cur_cnt unchanged.
REQ-026 SHALL, on simultaneous push_e & pop_e with cur_cnt==0, behave as a plain push, set pop_valid <= 0, and pulse underflow.
REQ-027 SHALL give flush priority over everything else: cur_ptr <= flush_ptr, cur_cnt <= min(flush_cnt, DEPTH), pop_valid <= 0, and mem is not written.
REQ-028 SHALL have a latency of exactly 1 cycle from pop_e to pop_valid/pop_addr.
REQ-029 SHALL hold pop_valid high for one cycle only per successful pop; it is 0 otherwise.
REQ-030 SHALL make a push in cycle N visible to a pop in cycle N+1, so the pop returns that pushed address.
REQ-031 SHALL drive overflow and underflow as registered pulses lasting exactly 1 cycle, each 0 when no qualifying event occurred.
REQ-032 SHALL ignore push/pop when dec_en=0, leaving all state held.

Reset
REQ-033 SHALL, while rst=1, set cur_ptr=0, cur_cnt=0, pop_valid=0, pop_addr=0, overflow=0, and underflow=0 on the next edge.
REQ-034 SHALL NOT reset mem contents; entries are unobservable until written, because cur_cnt gates reads.
REQ-035 SHALL make rst override flush, push, and pop in the same cycle.

Verification
REQ-036 SHALL verify push/pop order: reset; push 0x1000, 0x2000, 0x3000; pop x3 -> pop_addr 0x3000, 0x2000, 0x1000 on consecutive cycles with pop_valid=1, and cur_cnt ends at 0.
REQ-037 SHALL verify overflow: 17 pushes of values 1..17 -> overflow pulses on the 17th, cur_cnt=16, cur_ptr=1; 16 pops return 17 down to 2.
REQ-038 SHALL verify underflow: pop on an empty stack -> pop_valid=0, underflow=1 for one cycle, cur_ptr=0, cur_cnt=0.
REQ-039 SHALL verify tail call: push 0xA0; then push 0xB0 with a pop in the same cycle -> pop_addr=0xA0 and cur_cnt=1; a following pop -> 0xB0.
REQ-040 SHALL verify flush restore: push x3 (capture cur_ptr=1 and cur_cnt=1 after the first push); flush with the captured values together with a push -> cur_ptr=1, cur_cnt=1, and the next pop returns the first address.
REQ-041 SHALL verify reset mid-operation: after 5 pushes assert rst -> all outputs 0; a following pop gives underflow=1.
